inst_queue: RTL and testbench

Parametrised instruction queue between IF and ID. It replaces the single-entry IF→ID latch with a DEPTH-entry FIFO, so IF can run ahead while ID stalls on hazards or EXE back-pressure. It uses the same valid/allowin handshake on both sides and the same flush source as the pipeline. Each entry carries PC, NPC, NNPC, instruction, exception flag, ExcCode and error VAddr.

---
 rtl/inst_queue_pkg.sv | 50 +++++
 rtl/inst_queue_iq_ram.sv | 28 ++
 rtl/inst_queue.sv | 144 ++++++++++++++
 tb/tb_inst_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: payload layout,
// pack helper and the IF-stage reset constants shown while the queue is empty.
package inst_queue_pkg;

  // Packed payload word: {PC, NPC, NNPC, Instruct, exception, ExcCode, error_VAddr}
  localparam int IQ_PAYLOAD_W  = 166;
  localparam int IQ_VADDR_LSB  = 0;
  localparam int IQ_EXCODE_LSB = 32;
  localparam int IQ_EXC_LSB    = 37;
  localparam int IQ_INSTR_LSB  = 38;
  localparam int IQ_NNPC_LSB   = 70;
  localparam int IQ_NPC_LSB    = 102;
  localparam int IQ_PC_LSB     = 134;

  // IF-stage reset values, presented on the payload outputs when empty
  localparam logic [31:0] INI_IF_PC_IN          = 32'hBFC0_0000;
  localparam logic [31:0] INI_IF_NPC_IN         = 32'hBFC0_0004;
  localparam logic [31:0] INI_IF_NNPC_IN        = 32'hBFC0_0008;
  localparam logic [31:0] INI_IF_INSTRUCT_IN    = 32'h0000_0000;
  localparam logic        INI_IF_EXCEPTION_IN   = 1'b0;
  localparam logic [4:0]  INI_IF_EXCCODE_IN     = 5'h00;
  localparam logic [31:0] INI_IF_ERROR_VADDR_IN = 32'h0000_0000;

  // Pack one entry into the storage word using the offsets above
  function automatic logic [IQ_PAYLOAD_W-1:0] iq_pack(
    input logic [31:0] pc,
    input logic [31:0] npc,
    input logic [31:0] nnpc,
    input logic [31:0] instr,
    input logic        exc,
    input logic [4:0]  exc_code,
    input logic [31:0] vaddr
  );
    logic [IQ_PAYLOAD_W-1:0] w;
    w = '0;
    w[IQ_PC_LSB     +: 32] = pc;
    w[IQ_NPC_LSB    +: 32] = npc;
    w[IQ_NNPC_LSB   +: 32] = nnpc;
    w[IQ_INSTR_LSB  +: 32] = instr;
    w[IQ_EXC_LSB]          = exc;
    w[IQ_EXCODE_LSB +: 5]  = exc_code;
    w[IQ_VADDR_LSB  +: 32] = vaddr;
    return w;
  endfunction

  localparam logic [IQ_PAYLOAD_W-1:0] IQ_INI_WORD = iq_pack(
    INI_IF_PC_IN, INI_IF_NPC_IN, INI_IF_NNPC_IN, INI_IF_INSTRUCT_IN,
    INI_IF_EXCEPTION_IN, INI_IF_EXCCODE_IN, INI_IF_ERROR_VADDR_IN);

endpackage

// File: rtl/inst_queue_iq_ram.sv
// iq_ram: DEPTH x W storage, one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset; the queue never shows
// an entry that was not written since the last flush/reset.
module iq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 166,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: store the pushed entry at the write pointer
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// inst_queue: DEPTH-entry FIFO between IF and ID using the pipeline's
// valid/allowin handshake. Any flush (WB exception/eret or ID redirect)
// empties it in one cycle.
// Optional feature macro: IQ_BYPASS_EN -- zero-latency pass-through of the
// IF entry to ID when the queue is empty.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_in,
  output logic             iq_allowin_out,
  input  logic [31:0]      if_PC_in,
  input  logic [31:0]      if_NPC_in,
  input  logic [31:0]      if_NNPC_in,
  input  logic [31:0]      if_Instruct_in,
  input  logic             if_exception_in,
  input  logic [4:0]       if_ExcCode_in,
  input  logic [31:0]      if_error_VAddr_in,
  input  logic             id_allowin_in,
  output logic             iq_valid_out,
  output logic [31:0]      iq_PC_out,
  output logic [31:0]      iq_NPC_out,
  output logic [31:0]      iq_NNPC_out,
  output logic [31:0]      iq_Instruct_out,
  output logic             iq_exception_out,
  output logic [4:0]       iq_ExcCode_out,
  output logic [31:0]      iq_error_VAddr_out,
  input  logic             wb_ClrStpJmp_in,
  input  logic             id_redirect_in,
  output logic [CNT_W-1:0] iq_count_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q,  count_d;
  logic                    flush_s, empty_s, full_s;
  logic                    push_s, pop_s, bypass_s, bypass_take_s;
  logic [IQ_PAYLOAD_W-1:0] wdata_s, rdata_s, head_s;

  assign wdata_s = iq_pack(if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in,
                           if_exception_in, if_ExcCode_in, if_error_VAddr_in);

  // Handshake decode: flush, full/empty from the counter, push/pop qualifiers
  always_comb begin
    flush_s = wb_ClrStpJmp_in || id_redirect_in;
    empty_s = (count_q == '0);
    full_s  = (count_q == CNT_W'(DEPTH));
`ifdef IQ_BYPASS_EN
    bypass_s = empty_s && if_valid_in && !flush_s;
`else
    bypass_s = 1'b0;
`endif
    // An entry handed straight to ID is not also written into the array
    bypass_take_s = bypass_s && id_allowin_in;
    push_s = if_valid_in && !full_s && !flush_s && !bypass_take_s;
    pop_s  = !empty_s && id_allowin_in && !flush_s;
  end

  // Next-state for pointers and occupancy; flush returns everything to zero
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with synchronous active-low reset (same effect as flush)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  iq_ram #(
    .DEPTH (DEPTH),
    .W     (IQ_PAYLOAD_W),
    .AW    (PTR_W)
  ) u_iq_ram (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Head selection: bypassed IF entry, stored head, or reset constants
  always_comb begin
    head_s = IQ_INI_WORD;
    if (bypass_s) begin
      head_s = wdata_s;
    end else if (empty_s) begin
      head_s = IQ_INI_WORD;
    end else begin
      head_s = rdata_s;
    end
  end

  assign iq_allowin_out     = !full_s;
  assign iq_valid_out       = (!empty_s || bypass_s) && !flush_s;
  assign iq_count_out       = count_q;
  assign iq_PC_out          = head_s[IQ_PC_LSB     +: 32];
  assign iq_NPC_out         = head_s[IQ_NPC_LSB    +: 32];
  assign iq_NNPC_out        = head_s[IQ_NNPC_LSB   +: 32];
  assign iq_Instruct_out    = head_s[IQ_INSTR_LSB  +: 32];
  assign iq_exception_out   = head_s[IQ_EXC_LSB];
  assign iq_ExcCode_out     = head_s[IQ_EXCODE_LSB +: 5];
  assign iq_error_VAddr_out = head_s[IQ_VADDR_LSB  +: 32];

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             if_valid_in;
  logic             iq_allowin_out;
  logic [31:0]      if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in;
  logic             if_exception_in;
  logic [4:0]       if_ExcCode_in;
  logic [31:0]      if_error_VAddr_in;
  logic             id_allowin_in;
  logic             iq_valid_out;
  logic [31:0]      iq_PC_out, iq_NPC_out, iq_NNPC_out, iq_Instruct_out;
  logic             iq_exception_out;
  logic [4:0]       iq_ExcCode_out;
  logic [31:0]      iq_error_VAddr_out;
  logic             wb_ClrStpJmp_in;
  logic             id_redirect_in;
  logic [CNT_W-1:0] iq_count_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [165:0] model_q[$];

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_in(if_valid_in), .iq_allowin_out(iq_allowin_out),
    .if_PC_in(if_PC_in), .if_NPC_in(if_NPC_in), .if_NNPC_in(if_NNPC_in),
    .if_Instruct_in(if_Instruct_in), .if_exception_in(if_exception_in),
    .if_ExcCode_in(if_ExcCode_in), .if_error_VAddr_in(if_error_VAddr_in),
    .id_allowin_in(id_allowin_in), .iq_valid_out(iq_valid_out),
    .iq_PC_out(iq_PC_out), .iq_NPC_out(iq_NPC_out), .iq_NNPC_out(iq_NNPC_out),
    .iq_Instruct_out(iq_Instruct_out), .iq_exception_out(iq_exception_out),
    .iq_ExcCode_out(iq_ExcCode_out), .iq_error_VAddr_out(iq_error_VAddr_out),
    .wb_ClrStpJmp_in(wb_ClrStpJmp_in), .id_redirect_in(id_redirect_in),
    .iq_count_out(iq_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side entry layout (independent of the RTL's internal offsets)
  function automatic logic [165:0] in_word();
    return {if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in,
            if_exception_in, if_ExcCode_in, if_error_VAddr_in};
  endfunction

  function automatic logic [165:0] out_word();
    return {iq_PC_out, iq_NPC_out, iq_NNPC_out, iq_Instruct_out,
            iq_exception_out, iq_ExcCode_out, iq_error_VAddr_out};
  endfunction

  task automatic check(input string tag, input logic [165:0] obs, input logic [165:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_entry(input logic [31:0] pc);
    if_valid_in       = 1'b1;
    if_PC_in          = pc;
    if_NPC_in         = pc + 32'd4;
    if_NNPC_in        = pc + 32'd8;
    if_Instruct_in    = $urandom;
    if_exception_in   = 1'b0;
    if_ExcCode_in     = 5'h00;
    if_error_VAddr_in = 32'h0;
  endtask

  // One cycle: check outputs mid-cycle against the model, then advance it
  task automatic step();
    bit           flush, byp, accept, popped;
    int           cnt;
    logic [165:0] head_e, ini_e, in_e;
    #1;
    ini_e  = {INI_IF_PC_IN, INI_IF_NPC_IN, INI_IF_NNPC_IN, INI_IF_INSTRUCT_IN,
              INI_IF_EXCEPTION_IN, INI_IF_EXCCODE_IN, INI_IF_ERROR_VADDR_IN};
    in_e   = in_word();
    cnt    = model_q.size();
    flush  = wb_ClrStpJmp_in || id_redirect_in;
    byp    = BYP && (cnt == 0) && if_valid_in && !flush;
    head_e = (cnt > 0) ? model_q[0] : (byp ? in_e : ini_e);
    if (rst_n) begin
      check("valid",   {165'd0, iq_valid_out},   {165'd0, (!flush && (cnt > 0 || byp))});
      check("allowin", {165'd0, iq_allowin_out}, {165'd0, (cnt != DEPTH)});
      check("count",   {163'd0, iq_count_out},   {163'd0, 3'(cnt)});
      check("payload", out_word(), head_e);
    end
    @(posedge clk);
    if (!rst_n || flush) begin
      model_q.delete();
    end else begin
      accept = if_valid_in && (cnt != DEPTH);
      popped = (cnt > 0) && id_allowin_in;
      if (!(byp && id_allowin_in)) begin
        if (popped) void'(model_q.pop_front());
        if (accept) model_q.push_back(in_e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_valid_in = 1'b0; id_allowin_in = 1'b0;
    wb_ClrStpJmp_in = 1'b0; id_redirect_in = 1'b0;
    set_entry(32'h0); if_valid_in = 1'b0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;

    // Idle after reset
    repeat (3) step();

    // Fill to DEPTH with ID stalled, refused 5th offer, then in-order drain
    id_allowin_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_entry(32'hBFC0_0000 + 32'(4 * i));
      step();
    end
    set_entry(32'hBFC0_0010);
    step();
    check("full_allowin", {165'd0, iq_allowin_out}, 166'd0);
    if_valid_in = 1'b0; id_allowin_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", {134'd0, iq_PC_out}, {134'd0, 32'hBFC0_0000 + 32'(4 * i)});
      step();
    end
    step();

    // Occupancy held at 2 with simultaneous push+pop; pointers wrap
    id_allowin_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_entry(32'h8000_0000 + 32'(4 * i)); step();
    end
    id_allowin_in = 1'b1;
    for (int i = 2; i < 22; i++) begin
      set_entry(32'h8000_0000 + 32'(4 * i)); step();
    end
    if_valid_in = 1'b0;
    repeat (3) step();

    // Flush with 3 entries and a simultaneous push: redirect, then WB
    for (int f = 0; f < 2; f++) begin
      id_allowin_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
        set_entry(32'hA000_0000 + 32'(4 * i)); step();
      end
      set_entry(32'hBFC0_0100);
      if (f == 0) id_redirect_in = 1'b1; else wb_ClrStpJmp_in = 1'b1;
      step();
      id_redirect_in = 1'b0; wb_ClrStpJmp_in = 1'b0; if_valid_in = 1'b0;
      check("post_flush_count", {163'd0, iq_count_out}, 166'd0);
      step();
    end

    // Exception fields travel verbatim
    id_allowin_in = 1'b0;
    set_entry(32'hBFC0_0300);
    if_exception_in = 1'b1; if_ExcCode_in = 5'h04; if_error_VAddr_in = 32'hBFC0_0001;
    step();
    set_entry(32'h0); if_valid_in = 1'b0; id_allowin_in = 1'b1;
    check("exc_fields", {128'd0, iq_exception_out, iq_ExcCode_out, iq_error_VAddr_out},
          {128'd0, 1'b1, 5'h04, 32'hBFC0_0001});
    step(); step();

    // Empty queue, IF offers with ID ready (bypass or one-cycle latency)
    set_entry(32'hBFC0_0200); id_allowin_in = 1'b1;
    step();
    if_valid_in = 1'b0;
    step(); step();

    // Random traffic including sporadic flushes and mid-operation resets
    for (int c = 0; c < 600; c++) begin
      set_entry($urandom);
      if_valid_in       = ($urandom_range(0, 3) != 0);
      if_exception_in   = ($urandom_range(0, 7) == 0);
      if_ExcCode_in     = 5'($urandom);
      if_error_VAddr_in = $urandom;
      id_allowin_in     = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      id_redirect_in    = ($urandom_range(0, 31) == 0);
      wb_ClrStpJmp_in   = ($urandom_range(0, 31) == 0);
      rst_n             = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1'b1; if_valid_in = 1'b0; id_redirect_in = 1'b0; wb_ClrStpJmp_in = 1'b0;
    id_allowin_in = 1'b1;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
